// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port RAM arbiter between the icache fetch port and the
//               dcache block-transfer port. Data side has priority; a
//               starvation counter guarantees instruction forward progress.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] c_ACCESS = 2'b10;
    localparam logic [1:0] c_ERROR  = 2'b11;
    localparam int         c_CW     = $clog2(STARVE_MAX + 1);

    state_t          r_state;
    state_t          w_next;
    logic [c_CW-1:0] r_starve_cnt;
    logic [7:0]      r_err_cnt;
    logic            w_starved;
    logic            w_live;    // granted requester still holds its request
    logic            w_idone;   // instruction read completes this cycle

    assign w_starved = (r_starve_cnt == c_CW'(STARVE_MAX));
    assign err_cnt   = r_err_cnt;

    // Next-state and RAM/requester outputs; reset forces idle-looking outputs
    // so an abandoned transfer never produces a completion pulse.
    always_comb begin
        w_next   = r_state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        w_live   = 1'b0;
        w_idone  = 1'b0;
        if (RST) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iREN && w_starved)  w_next = IGRANT;
                    else if (dREN || dWEN)  w_next = DGRANT;
                    else if (iREN)          w_next = IGRANT;
                end
                DGRANT: begin
                    w_live = dREN || dWEN;
                    if (!w_live) begin
                        w_next = IDLE;
                    end else begin
                        ramaddr = daddr;
                        if (dWEN) begin
                            ramWEN   = 1'b1;
                            ramstore = dstore;
                        end else begin
                            ramREN = 1'b1;
                        end
                        if (ramstate == c_ACCESS) begin
                            dwait  = 1'b0;
                            dload  = dWEN ? '0 : ramload;
                            w_next = IDLE;
                        end
                    end
                end
                IGRANT: begin
                    w_live = iREN;
                    if (!w_live) begin
                        w_next = IDLE;
                    end else begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr;
                        if (ramstate == c_ACCESS) begin
                            iwait   = 1'b0;
                            iload   = ramload;
                            w_idone = 1'b1;
                            w_next  = IDLE;
                        end
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // State, starvation counter and saturating error counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (!iREN || w_idone)
                r_starve_cnt <= '0;
            else if (r_state != IGRANT && !w_starved)
                r_starve_cnt <= r_starve_cnt + c_CW'(1);
            if (w_live && ramstate == c_ERROR && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire
